// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM encodings, requester count and the priority-search result type.
package rr_arbiter4_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// 2-to-4 one-hot decoder with enable; a disabled decoder drives all zeros.
module decoder2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    // Expand the index to one-hot, suppressed while disabled
    always_comb begin
        y = 4'b0000;
        if (en) begin
            case (sel)
                2'd0:    y = 4'b0001;
                2'd1:    y = 4'b0010;
                2'd2:    y = 4'b0100;
                2'd3:    y = 4'b1000;
                default: y = 4'b0000;
            endcase
        end else begin
            y = 4'b0000;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and optional hold-limit
// rotation; the registered winner index drives a one-hot grant via decoder2to4.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    // Search order is last+1, last+2, last+3, last; masked bits never win.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req_v,
                                      input logic [1:0]      last_v,
                                      input logic [NREQ-1:0] excl_v);
        pick_t           p;
        logic [1:0]      cand;
        logic [NREQ-1:0] live;
        logic            hit;
        p.found = 1'b0;
        p.idx   = 2'd0;
        live    = req_v & ~excl_v;
        for (int i = 1; i <= NREQ; i++) begin
            cand    = last_v + 2'(i);
            hit     = !p.found && live[cand];
            p.idx   = hit ? cand : p.idx;
            p.found = p.found | hit;
        end
        return p;
    endfunction

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HOLD_SAT_C = {CNT_W{1'b1}};

    state_e           state_r, state_n_s;
    logic [1:0]       last_r, last_n_s;
    logic [1:0]       gnt_id_r, gnt_id_n_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_n_s;
    logic             preempt_r, preempt_n_s;
    logic [NREQ-1:0]  holder_mask_s;
    logic             hold_lim_s;
    pick_t            pick_any_s, pick_oth_s;

    // State and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_r     <= 2'd3;
            gnt_id_r   <= 2'd0;
            hold_cnt_r <= '0;
            preempt_r  <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            last_r     <= last_n_s;
            gnt_id_r   <= gnt_id_n_s;
            hold_cnt_r <= hold_cnt_n_s;
            preempt_r  <= preempt_n_s;
        end
    end

    // Next-state: arbitration, release, hold-limit rotation
    always_comb begin
        state_n_s     = state_r;
        last_n_s      = last_r;
        gnt_id_n_s    = gnt_id_r;
        hold_cnt_n_s  = hold_cnt_r;
        preempt_n_s   = 1'b0;
        holder_mask_s = 4'b0001 << gnt_id_r;
        pick_any_s    = rr_pick(req, last_r, 4'b0000);
        pick_oth_s    = rr_pick(req, last_r, holder_mask_s);
        // >= rather than == so a holder that outlived the limit alone still rotates
        hold_lim_s    = (MAX_HOLD != 32'sd0) && (hold_cnt_r >= HOLD_MAX_C);
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s.found) begin
                    state_n_s    = ST_GRANT;
                    gnt_id_n_s   = pick_any_s.idx;
                    last_n_s     = pick_any_s.idx;
                    hold_cnt_n_s = HOLD_ONE_C;
                end else begin
                    state_n_s    = ST_IDLE;
                    hold_cnt_n_s = '0;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id_r]) begin
                    // Release takes precedence over a coincident timeout
                    if (pick_oth_s.found) begin
                        gnt_id_n_s   = pick_oth_s.idx;
                        last_n_s     = pick_oth_s.idx;
                        hold_cnt_n_s = HOLD_ONE_C;
                    end else begin
                        state_n_s    = ST_IDLE;
                        hold_cnt_n_s = '0;
                    end
                end else if (hold_lim_s && pick_oth_s.found) begin
                    gnt_id_n_s   = pick_oth_s.idx;
                    last_n_s     = pick_oth_s.idx;
                    hold_cnt_n_s = HOLD_ONE_C;
                    preempt_n_s  = 1'b1;
                end else begin
                    hold_cnt_n_s = (hold_cnt_r == HOLD_SAT_C) ? hold_cnt_r
                                                              : hold_cnt_r + HOLD_ONE_C;
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                hold_cnt_n_s = '0;
            end
        endcase
    end

    assign gnt_id  = gnt_id_r;
    assign busy    = (state_r == ST_GRANT);
    assign preempt = preempt_r;

    decoder2to4 u_dec (
        .sel (gnt_id_r),
        .en  (busy),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with default MAX_HOLD=8; each scenario task
// drives inputs on the falling edge and checks outputs there.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    int total;
    int bad;

    rr_arbiter4 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL reset: gnt=%b busy=%b preempt=%b id=%0d, want 0000 0 0 0",
                     gnt, busy, preempt, gnt_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_grant();
        req = 4'b1111;
        tick();
        total++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL first_grant: gnt=%b id=%0d busy=%b preempt=%b, want 0001 0 1 0",
                     gnt, gnt_id, busy, preempt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] reqs [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0111};
        logic [3:0] exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            req = reqs[i];
            tick();
            total++;
            if (gnt !== exp[i] || busy !== 1'b1 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back[%0d]: gnt=%b busy=%b preempt=%b, want %b 1 0",
                         i, gnt, busy, preempt, exp[i]);
            end
        end
        req = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_release: gnt=%b busy=%b, want 0000 0", gnt, busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0001 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL hold0 cyc%0d: gnt=%b preempt=%b, want 0001 0", c, gnt, preempt);
            end
        end
        tick();
        total++;
        if (gnt !== 4'b0010 || preempt !== 1'b1) begin
            bad++;
            $display("FAIL rotate_to_1: gnt=%b preempt=%b, want 0010 1", gnt, preempt);
        end
        for (int c = 1; c < 8; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0010 || preempt !== 1'b0) begin
                bad++;
                $display("FAIL hold1 cyc%0d: gnt=%b preempt=%b, want 0010 0", c, gnt, preempt);
            end
        end
        tick();
        total++;
        if (gnt !== 4'b0001 || preempt !== 1'b1) begin
            bad++;
            $display("FAIL rotate_to_0: gnt=%b preempt=%b, want 0001 1", gnt, preempt);
        end
    endtask

    task automatic test_single();
        int seen_pre;
        int wrong_gnt;
        seen_pre  = 0;
        wrong_gnt = 0;
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (preempt !== 1'b0) seen_pre++;
            if (gnt !== 4'b0100) wrong_gnt++;
        end
        total++;
        if (wrong_gnt != 0 || seen_pre != 0) begin
            bad++;
            $display("FAIL single_requester: wrong_gnt_cycles=%0d preempt_cycles=%0d, want 0 0",
                     wrong_gnt, seen_pre);
        end
    endtask

    task automatic test_release_at_timeout();
        req = 4'b0000;
        tick();
        req = 4'b0101;
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL rel_timeout_grant: gnt=%b, want 0001", gnt);
        end
        for (int c = 1; c < 8; c++) tick();
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100 || preempt !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rel_timeout: gnt=%b preempt=%b busy=%b, want 0100 0 1",
                     gnt, preempt, busy);
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL pre_reset_grant: gnt=%b, want 0010", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: gnt=%b busy=%b preempt=%b, want 0000 0 0",
                     gnt, busy, preempt);
        end
        req = 4'b0000;
        @(negedge clk);
        tick();
        rst = 1'b0;
        req = 4'b1010;
        tick();
        total++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ptr: gnt=%b id=%0d busy=%b, want 0010 1 1",
                     gnt, gnt_id, busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        test_reset();
        test_grant();
        test_back_to_back();
        test_timeout();
        test_single();
        test_release_at_timeout();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that grants a single shared resource to one requester at a time and holds the grant until release or a hold-limit timeout. The winning 2-bit index is registered and expanded to a one-hot grant vector through a 2-to-4 decoder. It sits in front of any shared datapath (bus, memory port, ALU) that the decoder-addressed units contend for.

## Interface

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles before forced rotation when another requester is pending; 0 disables the limit.
- CNT_W, default 4: hold-counter width; MAX_HOLD must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] high = requester i wants or holds the resource.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- gnt_id  output  2  index of the current grant holder; valid only while busy=1.
- busy  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse on the cycle a grant is revoked by timeout.

## Operation

- States: IDLE (no grant) and GRANT (one holder, index in gnt_id).
- Priority pointer `last` (2 bits) holds the most recent winner. Search order is last+1, last+2, last+3, last (mod 4, wrap 3→0).
- IDLE: if any req is high, the first high bit in search order wins. Go to GRANT, set gnt_id=winner, last=winner, hold_cnt=1.
- GRANT, holder keeps req high:
  - MAX_HOLD=0, or hold_cnt < MAX_HOLD, or no other req pending: stay. hold_cnt increments and saturates at 2**CNT_W-1.
  - MAX_HOLD>0, hold_cnt == MAX_HOLD, and another req is pending: revoke. The search excludes the holder. Grant the winner next cycle (hold_cnt=1) and pulse preempt.
- GRANT, holder drops req: release. If another req is high, grant the next winner in search order back-to-back (no idle bubble). Otherwise go to IDLE.
- Simultaneous release and timeout on the same cycle: treat as release; preempt stays low.
- A requester that was just preempted may re-win only after every other pending requester has been served, which follows from the pointer order.
- gnt is the decoder output of gnt_id, gated by busy. It is never more than one-hot.
- Requests that rise and fall within one cycle while another requester holds the grant are not remembered (no request latching).

## Timing

- Reset, async: state=IDLE, gnt=4'b0000, gnt_id=2'd0, busy=0, preempt=0, hold_cnt=0, last=2'd3, so requester 0 has top priority after reset.
- Grant latency: req sampled high at edge n → gnt high after edge n+1 (1 cycle).
- Release latency: holder req low at edge n → its gnt low after edge n+1. A new grant, if any, appears in the same cycle.
- Timeout: the holder with continuous req and pending contenders keeps gnt for exactly MAX_HOLD cycles.
- preempt is high for exactly the first cycle of the new grant.
- Reset asserted mid-grant: all outputs clear immediately without waiting for a clock. Arbitration resumes on the first edge after rst deasserts.

## Structure

- Shared package/header: state encodings (ST_IDLE=1'b0, ST_GRANT=1'b1) and the requester count constant NREQ=4.
- Sub-module: instantiate the existing decoder2to4 to produce the one-hot grant from gnt_id. busy gates its output.
- A combinational rotate-priority-encoder function (req, last, exclude mask → winner, found) lives inside the block.

## Test plan

- Reset then req=4'b1111 → gnt=4'b0001 after one edge, gnt_id=0, busy=1.
- Holder 0 drops req with req=4'b1110 → next cycle gnt=4'b0010 (back-to-back, no bubble). Drop each in turn → 0100, then 1000, then wraps to 0001.
- MAX_HOLD=8, req=4'b0011 held constant → gnt=0001 for 8 cycles, then gnt=0010 with preempt=1 for one cycle, then after 8 cycles back to 0001.
- Single requester req=4'b0100 held 20 cycles with MAX_HOLD=8 → gnt=0100 throughout, preempt never asserts.
- Timeout cycle coinciding with holder release → new grant issued, preempt=0.
- Assert rst mid-grant (gnt=0010) → gnt=0000 and busy=0 before the next edge. After release with req=4'b1010 → gnt=0010 (pointer reset to last=3).
